seg_scan: RTL and testbench

Parametrised multiplexed 7-segment display scanner. It generalises the fixed 12-bit prescaler / 2-bit digit selector to N digits, with per-digit masking, an anti-ghosting blank interval, hex-to-segment decode and a frame-complete strobe. It sits between the datapath registers holding display values and the board anode/segment pins.

---
 rtl/seg_scan.sv | 175 +++++++++++++++++
 tb/tb_seg_scan.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// Multiplexed N-digit 7-segment scanner: prescaled dwell, optional anti-ghost blank, hex decode.
// Optional feature macro SEG_SCAN_BRIGHT_EN adds a 4-bit brightness input that trims the lit dwell.
module seg_scan #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE_W   = 12,
  parameter int unsigned BLANK_CYCLES = 16,
  localparam int unsigned SEL_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
`ifdef SEG_SCAN_BRIGHT_EN
  input  logic [3:0]              brightness,
`endif
  output logic [SEL_W-1:0]        dig_sel,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    frame_pulse
);

  localparam int unsigned BC_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BC_W-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? BC_W'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [0:0] {StScan, StBlank} state_e;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  state_e                  r_state, w_state_nxt;
  logic [PRESCALE_W-1:0]   r_prescale, w_prescale_nxt;
  logic [BC_W-1:0]         r_blank_cnt, w_blank_nxt;
  logic [SEL_W-1:0]        r_dig_sel, w_sel_nxt, w_next_sel;
  logic [NUM_DIGITS-1:0]   r_an_n, w_an_nxt;
  logic [6:0]              r_seg_n;
  logic                    r_dp_n, r_frame, w_frame_nxt;
  logic                    w_tick, w_advance, w_any_en, w_bright_ok, w_lit;
  logic [3:0]              w_nib;
  logic                    w_dp_cur, w_en_cur;

  assign w_tick = (&r_prescale) && enable;

`ifdef SEG_SCAN_BRIGHT_EN
  assign w_bright_ok = (r_prescale[PRESCALE_W-1 -: 4] <= brightness);
`else
  assign w_bright_ok = 1'b1;
`endif

  // Per-digit fields of the currently selected digit.
  always_comb begin
    w_nib    = '0;
    w_dp_cur = 1'b0;
    w_en_cur = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_dig_sel == SEL_W'(i)) begin
        w_nib    = digits[4*i +: 4];
        w_dp_cur = dp_in[i];
        w_en_cur = digit_en[i];
      end
    end
  end

  // Nearest enabled index above the current one, wrapping; highest offset scanned first
  // so the smallest offset wins.
  always_comb begin
    int v_idx;
    v_idx      = 0;
    w_next_sel = r_dig_sel;
    w_any_en   = 1'b0;
    for (int k = int'(NUM_DIGITS); k >= 1; k--) begin
      v_idx = (int'(r_dig_sel) + k) % int'(NUM_DIGITS);
      if (digit_en[v_idx]) begin
        w_next_sel = SEL_W'(v_idx);
        w_any_en   = 1'b1;
      end
    end
  end

  always_comb begin
    w_prescale_nxt = r_prescale;
    w_blank_nxt    = r_blank_cnt;
    w_state_nxt    = r_state;
    w_sel_nxt      = r_dig_sel;
    w_frame_nxt    = 1'b0;
    w_advance      = 1'b0;
    if (enable) begin
      unique case (r_state)
        StScan: begin
          w_prescale_nxt = r_prescale + 1'b1;
          if (w_tick) begin
            if (BLANK_CYCLES == 0) begin
              w_advance = 1'b1;
            end else begin
              w_state_nxt = StBlank;
              w_blank_nxt = BLANK_LOAD;
            end
          end
        end
        StBlank: begin
          if (r_blank_cnt == '0) begin
            w_advance   = 1'b1;
            w_state_nxt = StScan;
          end else begin
            w_blank_nxt = r_blank_cnt - 1'b1;
          end
        end
        default: w_state_nxt = StScan;
      endcase
    end
    // An empty mask holds the selection and suppresses the frame strobe.
    if (w_advance && w_any_en) begin
      w_sel_nxt   = w_next_sel;
      w_frame_nxt = (w_next_sel <= r_dig_sel);
    end
  end

  assign w_lit = (r_state == StScan) && enable && w_en_cur && w_bright_ok;

  always_comb begin
    w_an_nxt = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (w_lit && (r_dig_sel == SEL_W'(i))) w_an_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StScan;
      r_prescale  <= '0;
      r_blank_cnt <= '0;
      r_dig_sel   <= '0;
      r_an_n      <= '1;
      r_seg_n     <= 7'h7F;
      r_dp_n      <= 1'b1;
      r_frame     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prescale  <= w_prescale_nxt;
      r_blank_cnt <= w_blank_nxt;
      r_dig_sel   <= w_sel_nxt;
      r_an_n      <= w_an_nxt;
      r_seg_n     <= f_decode(w_nib);
      r_dp_n      <= ~w_dp_cur;
      r_frame     <= w_frame_nxt;
    end
  end

  assign dig_sel     = r_dig_sel;
  assign an_n        = r_an_n;
  assign seg_n       = r_seg_n;
  assign dp_n        = r_dp_n;
  assign frame_pulse = r_frame;

endmodule

// File: tb/tb_seg_scan.sv
// Randomised bench for seg_scan: slot-phase reference model checked every cycle, plus
// hand-computed literal checks on the 4-digit, 16-cycle dwell, 2-cycle blank configuration.
module tb_seg_scan;
  localparam int N     = 4;
  localparam int PW    = 4;
  localparam int BC    = 2;
  localparam int DWELL = 1 << PW;
  localparam int SLOT  = DWELL + BC;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic [1:0]  dig_sel;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_pulse;
`ifdef SEG_SCAN_BRIGHT_EN
  logic [3:0]  bright = 4'hF;
`endif

  seg_scan #(.NUM_DIGITS(N), .PRESCALE_W(PW), .BLANK_CYCLES(BC)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .digits      (digits),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
`ifdef SEG_SCAN_BRIGHT_EN
    .brightness  (bright),
`endif
    .dig_sel     (dig_sel),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_pulse (frame_pulse)
  );

  always #5 clock = ~clock;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each digit owns a slot of SLOT enabled cycles, the first DWELL lit, the rest blank.
  int         m_phase = 0;
  int         m_sel   = 0;
  bit         m_valid = 1'b0;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_frame;
  int         nxt;
  bit         lit;

  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0; m_sel = 0; m_valid = 1'b1;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
    end else if (m_valid) begin
      lit = (m_phase < DWELL) && enable && digit_en[m_sel];
`ifdef SEG_SCAN_BRIGHT_EN
      lit = lit && ((m_phase >> (PW - 4)) <= int'(bright));
`endif
      e_an    = lit ? ~(4'b0001 << m_sel) : 4'hF;
      e_seg   = seg_tab[digits[4*m_sel +: 4]];
      e_dp    = ~dp_in[m_sel];
      e_frame = 1'b0;
      if (enable) begin
        if (m_phase == SLOT - 1) begin
          m_phase = 0;
          nxt = -1;
          for (int k = 1; k <= N; k++) begin
            if (digit_en[(m_sel + k) % N]) begin
              nxt = (m_sel + k) % N;
              break;
            end
          end
          if (nxt >= 0) begin
            e_frame = (nxt <= m_sel);
            m_sel   = nxt;
          end
        end else begin
          m_phase++;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("dig_sel", 32'(dig_sel), 32'(m_sel));
      check("an_n", 32'(an_n), 32'(e_an));
      check("seg_n", 32'(seg_n), 32'(e_seg));
      check("dp_n", 32'(dp_n), 32'(e_dp));
      check("frame_pulse", 32'(frame_pulse), 32'(e_frame));
    end
  end

  int cnt_a, cnt_b, sel_hold;
  bit found;

  initial begin
    digits = 16'hF830; dp_in = 4'b0010; digit_en = 4'hF;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0; enable = 1'b1;
    cnt_a = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      if (k <= 20 && an_n == 4'b1110) cnt_a++;
      if (k == 1) begin
        check("lit_an_d0", 32'(an_n), 32'hE);
        check("lit_seg_d0", 32'(seg_n), 32'b1000000);
        check("lit_dp_d0", 32'(dp_n), 32'h1);
      end
      if (k == 17) check("lit_an_blank1", 32'(an_n), 32'hF);
      if (k == 18) begin
        check("lit_an_blank2", 32'(an_n), 32'hF);
        check("lit_sel_adv", 32'(dig_sel), 32'h1);
      end
      if (k == 19) begin
        check("lit_an_d1", 32'(an_n), 32'hD);
        check("lit_seg_d1", 32'(seg_n), 32'b0110000);
        check("lit_dp_d1", 32'(dp_n), 32'h0);
      end
      if (k == 37) check("lit_seg_d2", 32'(seg_n), 32'b0000000);
      if (k == 55) check("lit_seg_d3", 32'(seg_n), 32'b0001110);
      if (k == 71) check("lit_frame_pre", 32'(frame_pulse), 32'h0);
      if (k == 72) begin
        check("lit_frame_wrap", 32'(frame_pulse), 32'h1);
        check("lit_sel_wrap", 32'(dig_sel), 32'h0);
      end
    end
    check("lit_an_d0_count", 32'(cnt_a), 32'd16);

    // Sparse mask 0101: only digits 0 and 2 visited.
    digit_en = 4'b0101;
    cnt_a = 0; cnt_b = 0;
    for (int k = 81; k <= 170; k++) begin
      @(negedge clock);
      if (frame_pulse) cnt_a++;
      if (an_n == 4'b1101 || an_n == 4'b0111) cnt_b++;
    end
    check("lit_sparse_frames", 32'(cnt_a), 32'd2);
    check("lit_sparse_an", 32'(cnt_b), 32'd0);

    // Freeze mid-scan at prescaler 5.
    digit_en = 4'hF;
    found = 1'b0;
    for (int i = 0; i < 4 * SLOT && !found; i++) begin
      @(negedge clock);
      if (m_phase == 5) found = 1'b1;
    end
    check("lit_wait_p5", 32'(found), 32'h1);
    sel_hold = m_sel;
    enable = 1'b0;
    repeat (10) @(negedge clock);
    check("lit_hold_an", 32'(an_n), 32'hF);
    check("lit_hold_sel", 32'(dig_sel), 32'(sel_hold));
    enable = 1'b1;
    repeat (30) @(negedge clock);

    // Empty mask: nothing lights, nothing strobes.
    digit_en = 4'h0;
    cnt_a = 0; cnt_b = 0;
    repeat (200) begin
      @(negedge clock);
      if (frame_pulse) cnt_a++;
      if (an_n != 4'hF) cnt_b++;
    end
    check("lit_empty_frames", 32'(cnt_a), 32'd0);
    check("lit_empty_an", 32'(cnt_b), 32'd0);

    // Reset asserted during the blank interval.
    digit_en = 4'hF;
    found = 1'b0;
    for (int i = 0; i < 4 * SLOT && !found; i++) begin
      @(negedge clock);
      if (m_phase >= DWELL && m_sel != 0) found = 1'b1;
    end
    check("lit_wait_blank", 32'(found), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("lit_rst_sel", 32'(dig_sel), 32'h0);
    check("lit_rst_an", 32'(an_n), 32'hF);
    check("lit_rst_seg", 32'(seg_n), 32'h7F);
    check("lit_rst_frame", 32'(frame_pulse), 32'h0);
    @(negedge clock);
    check("lit_rst_resume", 32'(an_n), 32'hE);

    // Randomised traffic.
    repeat (3000) begin
      @(negedge clock);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 29) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 149) == 0) digit_en = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
